// File: rtl/efuse_array_rsp.sv
// efuse_array_rsp: 256-bit one-time-programmable fuse array model with protocol checking.
// Latency: rsp_pgm_done one cycle after the aen fall of an accepted program; read byte registered.
// Backpressure: none; the controller drives the access strobes, so protocol violations raise a sticky error.
//
// Ports:
//   clk, rst_n         single clock, asynchronous active-low reset
//   efuse_pgmen_i      program mode
//   efuse_rden_i       read mode
//   efuse_aen_i        access strobe (pulse width sets program/read timing)
//   efuse_addr_i       program: bit index [7:0]; read: byte index [4:0]
//   rsp_err_clr        clears the sticky error and its code
//   efuse_rdata_o      read byte (8'h00 when not valid)
//   rsp_pgm_done       one-cycle pulse per accepted program
//   rsp_err            sticky protocol error
//   rsp_err_code       first error captured: 1 both modes, 2 addr change, 3 no mode,
//                      4 mode dropped, 5 short program pulse
//   rsp_pgm_cnt        number of bits newly blown since reset
//
// Build option: EFUSE_RSP_TIMING_CHK_EN enforces TPGM_MIN / TRD_MIN pulse widths
// and error 5; without it any program pulse is accepted and read data is valid
// the cycle after the aen rise.

module efuse_array_rsp #(
  parameter int           TPGM_MIN = 16,
  parameter int           TRD_MIN  = 8,
  parameter logic [255:0] INIT_VAL = 256'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       efuse_pgmen_i,
  input  logic       efuse_rden_i,
  input  logic       efuse_aen_i,
  input  logic [7:0] efuse_addr_i,
  input  logic       rsp_err_clr,
  output logic [7:0] efuse_rdata_o,
  output logic       rsp_pgm_done,
  output logic       rsp_err,
  output logic [2:0] rsp_err_code,
  output logic [8:0] rsp_pgm_cnt
);

`ifdef EFUSE_RSP_TIMING_CHK_EN
  localparam bit TIMING_CHK = 1'b1;
`else
  localparam bit TIMING_CHK = 1'b0;
`endif

  // Minimum number of aen-high cycles; with checking off a single cycle suffices.
  localparam logic [10:0] PGM_LEN = TIMING_CHK ? 11'(TPGM_MIN) : 11'd1;
  localparam logic [10:0] RD_LEN  = TIMING_CHK ? 11'(TRD_MIN)  : 11'd1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PGM_PULSE = 2'd1,
    RD_PULSE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           aen_q;
  logic           aen_rise;
  logic [7:0]     addr_q;
  logic [9:0]     cnt_q, cnt_d;
  logic [255:0]   fuse_q;

  logic           err1, err2, err3, err4, err5, err_vld;
  logic [2:0]     err_code;
  logic           pgm_start, rd_start, pgm_accept, rd_load;
  logic [10:0]    pgm_len, rd_len;
  logic [4:0]     rd_idx;
  logic [7:0]     rd_byte;

  assign aen_rise = efuse_aen_i & ~aen_q;

  // Pulse length seen at the aen fall: counter was cleared on the rise cycle
  // and advanced on every later high cycle.
  assign pgm_len = {1'b0, cnt_q} + 11'd1;

  // Protocol checks, evaluated every cycle.
  assign err1 = efuse_pgmen_i & efuse_rden_i;
  assign err2 = (state_q != IDLE) & efuse_aen_i & (efuse_addr_i != addr_q);
  assign err3 = (state_q == IDLE) & aen_rise & ~efuse_pgmen_i & ~efuse_rden_i;
  assign err4 = efuse_aen_i & (((state_q == PGM_PULSE) & ~efuse_pgmen_i) |
                               ((state_q == RD_PULSE)  & ~efuse_rden_i));
  assign err5 = TIMING_CHK & (state_q == PGM_PULSE) & ~efuse_aen_i & (pgm_len < PGM_LEN);
  assign err_vld = err1 | err2 | err3 | err4 | err5;

  // Lowest code wins when several violations coincide.
  always_comb begin
    err_code = 3'd0;
    if (err1)      err_code = 3'd1;
    else if (err2) err_code = 3'd2;
    else if (err3) err_code = 3'd3;
    else if (err4) err_code = 3'd4;
    else if (err5) err_code = 3'd5;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pgm_start  = 1'b0;
    rd_start   = 1'b0;
    pgm_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (aen_rise && efuse_pgmen_i && !efuse_rden_i) begin
          state_d   = PGM_PULSE;
          pgm_start = 1'b1;
        end else if (aen_rise && efuse_rden_i && !efuse_pgmen_i) begin
          state_d  = RD_PULSE;
          rd_start = 1'b1;
        end
      end
      PGM_PULSE: begin
        if (!efuse_aen_i) begin
          state_d    = IDLE;
          pgm_accept = 1'b1;
        end
      end
      RD_PULSE: begin
        if (!efuse_aen_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Any violation aborts the access without touching the array.
    if (err_vld) begin
      state_d    = IDLE;
      pgm_start  = 1'b0;
      rd_start   = 1'b0;
      pgm_accept = 1'b0;
    end
  end

  always_comb begin
    if (pgm_start || rd_start)                    cnt_d = '0;
    else if ((state_q != IDLE) && efuse_aen_i)    cnt_d = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;
    else                                          cnt_d = cnt_q;
  end

  // Read data is captured on the edge where the pulse reaches its required
  // length, so it appears the following cycle. On the rise cycle the address
  // is not latched yet, so take it straight from the port.
  assign rd_len  = {1'b0, cnt_d} + 11'd1;
  assign rd_load = efuse_rden_i & (rd_start | ((state_q == RD_PULSE) & efuse_aen_i & ~err_vld)) &
                   (rd_len >= RD_LEN);
  assign rd_idx  = (state_q == IDLE) ? efuse_addr_i[4:0] : addr_q[4:0];
  assign rd_byte = fuse_q[{rd_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aen_q         <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      fuse_q        <= INIT_VAL;
      efuse_rdata_o <= 8'h00;
      rsp_pgm_done  <= 1'b0;
      rsp_pgm_cnt   <= '0;
      rsp_err       <= 1'b0;
      rsp_err_code  <= 3'd0;
    end else begin
      aen_q        <= efuse_aen_i;
      cnt_q        <= cnt_d;
      rsp_pgm_done <= pgm_accept;

      if (pgm_start || rd_start) addr_q <= efuse_addr_i;

      // Fuses only ever blow; the count tracks bits that were still intact.
      if (pgm_accept) begin
        fuse_q[addr_q] <= 1'b1;
        if (!fuse_q[addr_q]) rsp_pgm_cnt <= rsp_pgm_cnt + 9'd1;
      end

      if (!efuse_rden_i)  efuse_rdata_o <= 8'h00;
      else if (rd_load)   efuse_rdata_o <= rd_byte;
      else if (rd_start)  efuse_rdata_o <= 8'h00;

      // First error sticks; a clear in the same cycle as a new error lets the
      // new code in.
      if (err_vld && (!rsp_err || rsp_err_clr)) begin
        rsp_err      <= 1'b1;
        rsp_err_code <= err_code;
      end else if (!err_vld && rsp_err_clr) begin
        rsp_err      <= 1'b0;
        rsp_err_code <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_efuse_array_rsp.sv
// tb_efuse_array_rsp: directed + randomized checks of efuse_array_rsp against a
// transaction-level model (bit array, blown-bit count, sticky error).
module tb_efuse_array_rsp;

  localparam int TPGM_MIN = 16;
  localparam int TRD_MIN  = 8;
`ifdef EFUSE_RSP_TIMING_CHK_EN
  localparam int PGM_LEN = TPGM_MIN;
  localparam int RD_LEN  = TRD_MIN;
`else
  localparam int PGM_LEN = 1;
  localparam int RD_LEN  = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       efuse_pgmen_i = 1'b0;
  logic       efuse_rden_i = 1'b0;
  logic       efuse_aen_i = 1'b0;
  logic [7:0] efuse_addr_i = 8'h00;
  logic       rsp_err_clr = 1'b0;
  logic [7:0] efuse_rdata_o;
  logic       rsp_pgm_done;
  logic       rsp_err;
  logic [2:0] rsp_err_code;
  logic [8:0] rsp_pgm_cnt;

  efuse_array_rsp #(.TPGM_MIN(TPGM_MIN), .TRD_MIN(TRD_MIN), .INIT_VAL(256'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .efuse_pgmen_i (efuse_pgmen_i),
    .efuse_rden_i  (efuse_rden_i),
    .efuse_aen_i   (efuse_aen_i),
    .efuse_addr_i  (efuse_addr_i),
    .rsp_err_clr   (rsp_err_clr),
    .efuse_rdata_o (efuse_rdata_o),
    .rsp_pgm_done  (rsp_pgm_done),
    .rsp_err       (rsp_err),
    .rsp_err_code  (rsp_err_code),
    .rsp_pgm_cnt   (rsp_pgm_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  bit fuse_m[256];
  int cnt_m;
  bit err_m;
  int code_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_m(input logic [7:0] a);
    logic [7:0] v;
    int base;
    base = 8 * int'(a[4:0]);
    for (int b = 0; b < 8; b++) v[b] = fuse_m[base + b];
    return v;
  endfunction

  task automatic model_err(input int c);
    if (!err_m) begin
      err_m  = 1'b1;
      code_m = c;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) fuse_m[i] = 1'b0;
    cnt_m  = 0;
    err_m  = 1'b0;
    code_m = 0;
  endtask

  task automatic status(input string tag);
    check({tag, "_err"},  rsp_err,      err_m);
    check({tag, "_code"}, rsp_err_code, code_m);
    check({tag, "_cnt"},  rsp_pgm_cnt,  cnt_m);
  endtask

  // Program bit a with an n-cycle aen pulse; drop_at>0 drops pgmen after that
  // many high cycles (mode-deasserted violation).
  task automatic pgm(input logic [7:0] a, input int n, input int drop_at);
    logic exp_done;
    efuse_pgmen_i = 1'b1;
    efuse_rden_i  = 1'b0;
    efuse_addr_i  = a;
    efuse_aen_i   = 1'b1;
    for (int k = 1; k <= n; k++) begin
      if (drop_at != 0 && k == drop_at + 1) efuse_pgmen_i = 1'b0;
      tick();
      check("pgm_done_during", rsp_pgm_done, 1'b0);
    end
    efuse_aen_i = 1'b0;
    tick();
    if (drop_at != 0) begin
      model_err(4);
      exp_done = 1'b0;
    end else if (n < PGM_LEN) begin
      model_err(5);
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b1;
      if (!fuse_m[a]) cnt_m++;
      fuse_m[a] = 1'b1;
    end
    check("pgm_done", rsp_pgm_done, exp_done);
    efuse_pgmen_i = 1'b0;
    tick();
    check("pgm_done_after", rsp_pgm_done, 1'b0);
    status("pgm");
  endtask

  task automatic rd(input logic [7:0] a, input int n);
    logic [7:0] exp_b;
    exp_b = byte_m(a);
    efuse_rden_i = 1'b1;
    efuse_addr_i = a;
    efuse_aen_i  = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      check("rd_pulse", efuse_rdata_o, (k >= RD_LEN) ? exp_b : 8'h00);
    end
    efuse_aen_i = 1'b0;
    tick();
    check("rd_fall", efuse_rdata_o, (n >= RD_LEN) ? exp_b : 8'h00);
    tick();
    check("rd_hold", efuse_rdata_o, (n >= RD_LEN) ? exp_b : 8'h00);
    efuse_rden_i = 1'b0;
    tick();
    check("rd_off", efuse_rdata_o, 8'h00);
    status("rd");
  endtask

  task automatic clr();
    rsp_err_clr = 1'b1;
    tick();
    rsp_err_clr = 1'b0;
    err_m  = 1'b0;
    code_m = 0;
    status("clr");
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_rdata", efuse_rdata_o, 8'h00);
    check("rst_done",  rsp_pgm_done,  1'b0);
    status("rst");
    rst_n = 1'b1;
    tick();

`ifdef EFUSE_RSP_TIMING_CHK_EN
    // Short program pulse is rejected and leaves the fuse intact.
    pgm(8'h13, 15, 0);
    check("short_code", rsp_err_code, 3'd5);
    rd(8'h02, 8);
    clr();
`else
    // Any pulse width is accepted.
    pgm(8'h40, 1, 0);
    rd(8'h08, 1);
`endif

    // Basic program + read of bit 0x13 -> byte 2 = 8'h08.
    pgm(8'h13, 16, 0);
    rd(8'h02, 8);
    check("byte2", efuse_rdata_o == 8'h00 ? byte_m(8'h02) : 8'h00, 8'h08);

    // Both modes in IDLE, then an address change mid read keeps code 1.
    efuse_pgmen_i = 1'b1;
    efuse_rden_i  = 1'b1;
    tick();
    model_err(1);
    status("both");
    efuse_pgmen_i = 1'b0;
    efuse_rden_i  = 1'b0;
    tick();
    efuse_rden_i = 1'b1;
    efuse_addr_i = 8'h05;
    efuse_aen_i  = 1'b1;
    repeat (3) tick();
    efuse_addr_i = 8'h06;
    tick();
    model_err(2);
    efuse_aen_i = 1'b0;
    tick();
    efuse_rden_i = 1'b0;
    tick();
    check("addrchg_rdata", efuse_rdata_o, 8'h00);
    status("addrchg");
    clr();

    // aen rise with no mode, then clear colliding with a new error.
    efuse_aen_i = 1'b1;
    tick();
    model_err(3);
    efuse_aen_i = 1'b0;
    tick();
    status("nomode");
    rsp_err_clr   = 1'b1;
    efuse_pgmen_i = 1'b1;
    efuse_rden_i  = 1'b1;
    tick();
    err_m  = 1'b1;
    code_m = 1;
    rsp_err_clr   = 1'b0;
    efuse_pgmen_i = 1'b0;
    efuse_rden_i  = 1'b0;
    tick();
    status("clr_vs_err");
    clr();

    // Reprogramming a blown bit pulses done without counting.
    pgm(8'hFF, 16, 0);
    pgm(8'hFF, 16, 0);
    rd(8'h3F, 8);

    // Mode dropped mid program aborts it.
    pgm(8'h30, 16, 5);
    rd(8'h06, 8);
    clr();

    // Randomized mix against the model.
    for (int i = 0; i < 60; i++) begin
      int op, n, drop;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        n    = $urandom_range(1, 20);
        drop = 0;
        if (n >= 2 && $urandom_range(0, 7) == 0) drop = $urandom_range(1, n - 1);
        pgm(8'($urandom_range(0, 255)), n, drop);
      end else if (op <= 8) begin
        rd(8'($urandom_range(0, 255)), $urandom_range(1, 12));
      end else begin
        clr();
      end
    end

    // Reset in the middle of a program pulse abandons it.
    efuse_pgmen_i = 1'b1;
    efuse_addr_i  = 8'h77;
    efuse_aen_i   = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_rdata", efuse_rdata_o, 8'h00);
    check("midrst_done",  rsp_pgm_done,  1'b0);
    status("midrst");
    efuse_aen_i   = 1'b0;
    efuse_pgmen_i = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("midrst_done2", rsp_pgm_done, 1'b0);
    status("after_rst");
    rd(8'h0E, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
